seg7_countup_mux: RTL

SEG7_COUNTUP_MUX -- requirements
Module: seg7_countup_mux

---
 rtl/seg7_countup_mux.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seg7_countup_mux.sv
// seg7_countup_mux
//   Decimal (BCD) up/down counter with a prescaled tick, plus a multiplexed
//   7-segment scanner that shows one digit of the count per scan slot.
//
// Parameters
//   DIGITS    number of BCD digits counted and scanned (1..8)
//   TICK_DIV  clock cycles per count tick (>= 2)
//   SCAN_DIV  clock cycles per digit scan slot (>= 1)
//
// Ports
//   CLK100MHZ  in   clock, rising edge
//   ck_rst     in   asynchronous active-low reset
//   en         in   count enable (prescaler runs while high)
//   up_dn      in   1 = count up, 0 = count down
//   clear      in   synchronous clear of count and prescaler
//   count_bcd  out  current count, digit 0 in [3:0]
//   wrap       out  one-cycle pulse after a wrap-around edge
//   seg        out  {g,f,e,d,c,b,a}, active-high, registered
//   dig_sel    out  one-hot digit select, registered
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN  blank leading zero digits (digit 0 always shown)

module seg7_countup_mux #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  CLK100MHZ,
    input  logic                  ck_rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]            r_presc;
    logic [DIGITS-1:0][3:0]   r_cnt;
    logic                     r_wrap;
    logic [SW-1:0]            r_scan;
    logic [IW-1:0]            r_idx;
    logic [6:0]               r_seg;
    logic [DIGITS-1:0]        r_dig_sel;

    logic                     w_tick;
    logic [DIGITS-1:0][3:0]   w_cnt_up;
    logic [DIGITS-1:0][3:0]   w_cnt_dn;
    logic                     w_wrap_up;
    logic                     w_wrap_dn;
    logic [3:0]               w_digit;
    logic [6:0]               w_seg;

    assign count_bcd = r_cnt;
    assign wrap      = r_wrap;
    assign seg       = r_seg;
    assign dig_sel   = r_dig_sel;

    assign w_tick = en && (r_presc == PRESC_MAX);

    function automatic logic [6:0] f_dec(input logic [3:0] d);
        case (d)
            4'd0:    f_dec = 7'h3F;
            4'd1:    f_dec = 7'h06;
            4'd2:    f_dec = 7'h5B;
            4'd3:    f_dec = 7'h4F;
            4'd4:    f_dec = 7'h66;
            4'd5:    f_dec = 7'h6D;
            4'd6:    f_dec = 7'h7D;
            4'd7:    f_dec = 7'h07;
            4'd8:    f_dec = 7'h7F;
            4'd9:    f_dec = 7'h6F;
            default: f_dec = 7'h00;
        endcase
    endfunction

    // Ripple BCD increment/decrement; carry/borrow out of the top digit is the wrap.
    always_comb begin
        logic c_up;
        logic c_dn;
        w_cnt_up = r_cnt;
        w_cnt_dn = r_cnt;
        c_up     = 1'b1;
        c_dn     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_up) begin
                if (r_cnt[i] == 4'd9) begin
                    w_cnt_up[i] = 4'd0;
                end else begin
                    w_cnt_up[i] = r_cnt[i] + 4'd1;
                    c_up        = 1'b0;
                end
            end
            if (c_dn) begin
                if (r_cnt[i] == 4'd0) begin
                    w_cnt_dn[i] = 4'd9;
                end else begin
                    w_cnt_dn[i] = r_cnt[i] - 4'd1;
                    c_dn        = 1'b0;
                end
            end
        end
        w_wrap_up = c_up;
        w_wrap_dn = c_dn;
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        w_digit = r_cnt[r_idx];
        w_seg   = f_dec(w_digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            logic nz_above;
            nz_above = 1'b0;
            // Digit idx is blank when it and every more-significant digit are zero.
            for (int i = DIGITS - 1; i > 0; i--) begin
                nz_above = nz_above | (r_cnt[i] != 4'd0);
                if ((IW'(i) == r_idx) && !nz_above)
                    w_seg = 7'h00;
            end
        end
`endif
    end

    // Prescaler, count and wrap pulse.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else if (clear) begin
            r_presc <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (en) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_cnt   <= up_dn ? w_cnt_up : w_cnt_dn;
                    r_wrap  <= up_dn ? w_wrap_up : w_wrap_dn;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    // Free-running scan; outputs lag the scan index and count by one cycle.
    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            r_scan    <= '0;
            r_idx     <= '0;
            r_seg     <= 7'h00;
            r_dig_sel <= '0;
        end else begin
            if (r_scan == SCAN_MAX) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_seg     <= w_seg;
            r_dig_sel <= DIGITS'(1) << r_idx;
        end
    end

endmodule
